// File: rtl/anim_frame_sequencer.sv
// ---------------------------------------------------------------------------
// anim_frame_sequencer
//
// Frame-rate scheduler for animation playback. A runtime-programmable
// clock-enable divider paces the frame index. The index is driven by
// play/pause/step/stop commands. Everything runs on I_CLK; downstream logic
// advances one frame per frame_tick instead of using a derived clock.
//
// Ports:
//   I_CLK        clock
//   rst          synchronous, active-high reset
//   cmd_play     pulse: start or resume playback
//   cmd_pause    pulse: hold current frame and phase
//   cmd_step     pulse: advance one frame, then pause
//   cmd_stop     pulse: return to frame 0, clear phase
//   period_in    new frame period in I_CLK cycles (0 is treated as 1)
//   period_load  pulse: latch period_in and clear the phase counter
//   dir          0 = forward, 1 = reverse; sampled at each advance
//   loop         1 = wrap at the ends, 0 = halt at the ends
//   frame_idx    current frame (registered)
//   frame_tick   one-cycle pulse in the cycle after frame_idx changes
//   done         one-cycle pulse when an advance is blocked at an end
//   state        00 STOP, 01 PLAY, 10 PAUSE
// ---------------------------------------------------------------------------
module anim_frame_sequencer #(
  parameter int               DIV_W          = 24,
  parameter int               FRAME_W        = 4,
  parameter int               NUM_FRAMES     = 16,
  parameter logic [DIV_W-1:0] DEFAULT_PERIOD = 24'd5_000_000
) (
  input  logic               I_CLK,
  input  logic               rst,
  input  logic               cmd_play,
  input  logic               cmd_pause,
  input  logic               cmd_step,
  input  logic               cmd_stop,
  input  logic [DIV_W-1:0]   period_in,
  input  logic               period_load,
  input  logic               dir,
  input  logic               loop,
  output logic [FRAME_W-1:0] frame_idx,
  output logic               frame_tick,
  output logic               done,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);

  state_t             state_q;
  logic [DIV_W-1:0]   period_reg;
  logic [DIV_W-1:0]   count;
  logic [DIV_W-1:0]   period_new;
  logic               wrap;
  logic               step_only;
  logic               at_end;
  logic               advance;
  logic [FRAME_W-1:0] adv_idx;

  assign state = state_q;

  // A zero period would never wrap; it is coerced to one (advance every cycle).
  assign period_new = (period_in == '0) ? DIV_W'(1) : period_in;
  assign wrap       = (count == period_reg - 1'b1);

  // Step is lowest priority: any other command in the same cycle masks it.
  assign step_only  = cmd_step & ~cmd_play & ~cmd_pause & ~cmd_stop;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    at_end  = dir ? (frame_idx == '0) : (frame_idx == LAST_FRAME);
    adv_idx = frame_idx;
    if (!dir) adv_idx = at_end ? '0 : frame_idx + 1'b1;
    else      adv_idx = at_end ? LAST_FRAME : frame_idx - 1'b1;

    advance = 1'b0;
    case (state_q)
      ST_PLAY:           advance = wrap & ~cmd_pause & ~cmd_stop;
      ST_STOP, ST_PAUSE: advance = step_only;
      default:           advance = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; later assignments in this block override
  // earlier ones (stop over state moves, period_load over count updates).
  always_ff @(posedge I_CLK) begin
    if (rst) begin
      state_q    <= ST_STOP;
      frame_idx  <= '0;
      count      <= '0;
      period_reg <= DEFAULT_PERIOD;
      frame_tick <= 1'b0;
      done       <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      done       <= 1'b0;

      if (cmd_stop) begin
        state_q   <= ST_STOP;
        frame_idx <= '0;
        count     <= '0;
      end else begin
        case (state_q)
          ST_STOP: begin
            if (!cmd_pause) begin
              if (cmd_play)      state_q <= ST_PLAY;
              else if (cmd_step) state_q <= ST_PAUSE;
            end
          end
          ST_PLAY: begin
            // Pause freezes the phase counter so resume keeps the phase.
            if (cmd_pause)  state_q <= ST_PAUSE;
            else if (wrap)  count   <= '0;
            else            count   <= count + 1'b1;
          end
          ST_PAUSE: begin
            if (!cmd_pause) begin
              if (cmd_play)      state_q <= ST_PLAY;
              else if (cmd_step) count   <= '0;
            end
          end
          default: state_q <= ST_STOP;
        endcase

        if (advance) begin
          if (at_end && !loop) begin
            // Blocked at an end: hold the frame, report done, park in PAUSE.
            done    <= 1'b1;
            state_q <= ST_PAUSE;
            count   <= '0;
          end else begin
            frame_idx  <= adv_idx;
            frame_tick <= 1'b1;
          end
        end
      end

      // Accepted alongside any command; a coincident wrap still advances.
      if (period_load) begin
        period_reg <= period_new;
        count      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_anim_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_anim_frame_sequencer
//
// Self-checking bench for anim_frame_sequencer (NUM_FRAMES=4, FRAME_W=2,
// DIV_W=8, DEFAULT_PERIOD=7). Stimulus pushes the expected tick/done events
// (kind, frame index, cycle number) into a scoreboard queue; a monitor pops
// and compares them whenever the DUT pulses frame_tick or done. Inputs are
// driven on the falling edge, outputs sampled 1 ns after the rising edge or
// on the falling edge.
// ---------------------------------------------------------------------------
module tb_anim_frame_sequencer;

  logic       I_CLK;
  logic       rst;
  logic       cmd_play;
  logic       cmd_pause;
  logic       cmd_step;
  logic       cmd_stop;
  logic [7:0] period_in;
  logic       period_load;
  logic       dir;
  logic       loop;
  logic [1:0] frame_idx;
  logic       frame_tick;
  logic       done;
  logic [1:0] state;

  anim_frame_sequencer #(
    .DIV_W         (8),
    .FRAME_W       (2),
    .NUM_FRAMES    (4),
    .DEFAULT_PERIOD(8'd7)
  ) dut (
    .I_CLK      (I_CLK),
    .rst        (rst),
    .cmd_play   (cmd_play),
    .cmd_pause  (cmd_pause),
    .cmd_step   (cmd_step),
    .cmd_stop   (cmd_stop),
    .period_in  (period_in),
    .period_load(period_load),
    .dir        (dir),
    .loop       (loop),
    .frame_idx  (frame_idx),
    .frame_tick (frame_tick),
    .done       (done),
    .state      (state)
  );

  localparam int ST_STOP  = 0;
  localparam int ST_PLAY  = 1;
  localparam int ST_PAUSE = 2;

  typedef struct {
    logic is_done;
    int   idx;
    int   cyc;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  int  k;

  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  // Counts rising edges; at the falling edge after edge e, cyc == e.
  always @(posedge I_CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_ev(input logic is_done, input int idx, input int c);
    ev_t e;
    e.is_done = is_done;
    e.idx     = idx;
    e.cyc     = c;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of commands from a falling edge; returns at the next
  // falling edge, just after the edge that sampled them.
  task automatic drive(input logic play, input logic pause, input logic step,
                       input logic stop, input logic load, input logic [7:0] pin);
    cmd_play    = play;
    cmd_pause   = pause;
    cmd_step    = step;
    cmd_stop    = stop;
    period_load = load;
    period_in   = pin;
    @(negedge I_CLK);
    cmd_play    = 1'b0;
    cmd_pause   = 1'b0;
    cmd_step    = 1'b0;
    cmd_stop    = 1'b0;
    period_load = 1'b0;
    period_in   = '0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge I_CLK);
  endtask

  // Scoreboard monitor.
  always @(posedge I_CLK) begin
    ev_t e;
    #1;
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      check("ev_missed", cyc, exp_q[0].cyc);
      exp_q.delete(0);
    end
    if (frame_tick || done) begin
      check("tick_done_excl", int'(frame_tick & done), 0);
      if (exp_q.size() == 0) begin
        check("ev_unexpected", int'(frame_tick) + 2 * int'(done), 0);
      end else begin
        e = exp_q.pop_front();
        check("ev_kind", int'(done), int'(e.is_done));
        check("ev_idx", int'(frame_idx), e.idx);
        check("ev_cyc", cyc, e.cyc);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_play = 1'b0; cmd_pause = 1'b0; cmd_step = 1'b0;
    cmd_stop = 1'b0; period_load = 1'b0; period_in = '0; dir = 1'b0; loop = 1'b1;
    repeat (3) @(negedge I_CLK);
    rst = 1'b0;
    @(negedge I_CLK);

    // Reset state.
    check("rst_idx", int'(frame_idx), 0);
    check("rst_state", int'(state), ST_STOP);
    check("rst_tick", int'(frame_tick), 0);
    check("rst_done", int'(done), 0);

    // Default period (7) from STOP, then stop.
    k = cyc + 1;
    push_ev(1'b0, 1, k + 7);
    drive(1, 0, 0, 0, 0, 8'd0);
    check("play_state", int'(state), ST_PLAY);
    wait_until(k + 7);
    drive(0, 0, 0, 1, 0, 8'd0);
    check("stop_idx", int'(frame_idx), 0);
    check("stop_state", int'(state), ST_STOP);

    // Period 3 playback with wrap 1,2,3,0,1,2; then stop+play at frame 2.
    drive(0, 0, 0, 0, 1, 8'd3);
    k = cyc + 1;
    push_ev(1'b0, 1, k + 3);
    push_ev(1'b0, 2, k + 6);
    push_ev(1'b0, 3, k + 9);
    push_ev(1'b0, 0, k + 12);
    push_ev(1'b0, 1, k + 15);
    push_ev(1'b0, 2, k + 18);
    drive(1, 0, 0, 0, 0, 8'd0);
    check("p3_state", int'(state), ST_PLAY);
    wait_until(k + 18);
    check("p3_idx", int'(frame_idx), 2);
    drive(1, 0, 0, 1, 0, 8'd0);
    check("stopplay_idx", int'(frame_idx), 0);
    check("stopplay_state", int'(state), ST_STOP);
    check("stopplay_tick", int'(frame_tick), 0);

    // Pause beats play in the same cycle.
    drive(1, 0, 0, 0, 0, 8'd0);
    drive(1, 1, 0, 0, 0, 8'd0);
    check("pauseplay_state", int'(state), ST_PAUSE);
    drive(0, 0, 0, 1, 0, 8'd0);

    // Step to frame 2, then play forward with loop=0 at period 2.
    push_ev(1'b0, 1, cyc + 1);
    drive(0, 0, 1, 0, 0, 8'd0);
    check("step1_state", int'(state), ST_PAUSE);
    push_ev(1'b0, 2, cyc + 1);
    drive(0, 0, 1, 0, 0, 8'd0);
    check("step2_idx", int'(frame_idx), 2);
    drive(0, 0, 0, 0, 1, 8'd2);
    loop = 1'b0;
    k = cyc + 1;
    push_ev(1'b0, 3, k + 2);
    push_ev(1'b1, 3, k + 4);
    drive(1, 0, 0, 0, 0, 8'd0);
    wait_until(k + 4);
    check("end_idx", int'(frame_idx), 3);
    check("end_state", int'(state), ST_PAUSE);
    repeat (4) @(negedge I_CLK);
    check("end_hold_idx", int'(frame_idx), 3);
    check("end_hold_state", int'(state), ST_PAUSE);
    drive(0, 0, 0, 1, 0, 8'd0);
    loop = 1'b1;

    // Pause/resume keeps phase: period 5, pause with count=2, resume.
    drive(0, 0, 0, 0, 1, 8'd5);
    k = cyc + 1;
    drive(1, 0, 0, 0, 0, 8'd0);
    wait_until(k + 2);
    drive(0, 1, 0, 0, 0, 8'd0);
    repeat (10) @(negedge I_CLK);
    check("hold_state", int'(state), ST_PAUSE);
    check("hold_idx", int'(frame_idx), 0);
    k = cyc + 1;
    push_ev(1'b0, 1, k + 3);
    drive(1, 0, 0, 0, 0, 8'd0);
    wait_until(k + 3);
    check("resume_idx", int'(frame_idx), 1);
    drive(0, 0, 0, 1, 0, 8'd0);

    // Reverse stepping with wrap, then blocked at 0 with loop=0.
    dir = 1'b1;
    push_ev(1'b0, 3, cyc + 1);
    drive(0, 0, 1, 0, 0, 8'd0);
    check("rev_idx", int'(frame_idx), 3);
    check("rev_state", int'(state), ST_PAUSE);
    push_ev(1'b0, 2, cyc + 1);
    drive(0, 0, 1, 0, 0, 8'd0);
    check("rev2_idx", int'(frame_idx), 2);
    push_ev(1'b0, 1, cyc + 1);
    drive(0, 0, 1, 0, 0, 8'd0);
    push_ev(1'b0, 0, cyc + 1);
    drive(0, 0, 1, 0, 0, 8'd0);
    loop = 1'b0;
    push_ev(1'b1, 0, cyc + 1);
    drive(0, 0, 1, 0, 0, 8'd0);
    check("rev_end_idx", int'(frame_idx), 0);
    check("rev_end_state", int'(state), ST_PAUSE);
    drive(0, 0, 0, 1, 0, 8'd0);
    dir = 1'b0;
    loop = 1'b1;

    // Period 0 -> 1 (tick every cycle); reload 3 on a wrap cycle.
    drive(0, 0, 0, 0, 1, 8'd0);
    k = cyc + 1;
    push_ev(1'b0, 1, k + 1);
    push_ev(1'b0, 2, k + 2);
    push_ev(1'b0, 3, k + 3);
    push_ev(1'b0, 0, k + 4);
    drive(1, 0, 0, 0, 0, 8'd0);
    wait_until(k + 4);
    push_ev(1'b0, 1, k + 5);
    push_ev(1'b0, 2, k + 8);
    drive(0, 0, 0, 0, 1, 8'd3);
    wait_until(k + 8);
    drive(0, 1, 0, 0, 0, 8'd0);
    check("reload_state", int'(state), ST_PAUSE);
    check("reload_idx", int'(frame_idx), 2);

    // Reset mid-PLAY (with a play command in the reset cycle).
    k = cyc + 1;
    push_ev(1'b0, 3, k + 3);
    drive(1, 0, 0, 0, 0, 8'd0);
    wait_until(k + 4);
    rst = 1'b1;
    cmd_play = 1'b1;
    @(negedge I_CLK);
    rst = 1'b0;
    cmd_play = 1'b0;
    check("mid_rst_idx", int'(frame_idx), 0);
    check("mid_rst_state", int'(state), ST_STOP);
    check("mid_rst_tick", int'(frame_tick), 0);
    check("mid_rst_done", int'(done), 0);

    // Period restored to the default (7).
    k = cyc + 1;
    push_ev(1'b0, 1, k + 7);
    drive(1, 0, 0, 0, 0, 8'd0);
    wait_until(k + 7);
    drive(0, 0, 0, 1, 0, 8'd0);

    repeat (3) @(negedge I_CLK);
    check("sb_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/anim_frame_sequencer.md
# anim_frame_sequencer

Frame-rate scheduler for the animation projector. It holds a runtime-programmable clock-enable divider and sequences the frame index under play/pause/step/stop commands. Downstream frame-fetch and display logic advance one frame per `frame_tick`, with no derived clocks. It replaces fixed-ratio divided clocks as the pacing source for animation playback; everything runs on `I_CLK`.

## Interface
Parameters:
- `DIV_W`, 24: width of the period register and the phase counter.
- `FRAME_W`, 4: width of `frame_idx`.
- `NUM_FRAMES`, 16: frames in the animation; legal range 2..2^FRAME_W.
- `DEFAULT_PERIOD`, 24'd5_000_000: period loaded at reset, in `I_CLK` cycles per frame; must be ≥1.

Ports:
- `I_CLK` in 1: clock. Reset `rst` is synchronous, active-high; clock is `I_CLK`.
- `rst` in 1: synchronous active-high reset.
- `cmd_play` in 1: pulse; start or resume playback.
- `cmd_pause` in 1: pulse; hold the current frame and phase.
- `cmd_step` in 1: pulse; advance exactly one frame, then pause.
- `cmd_stop` in 1: pulse; return to frame 0 and clear the phase.
- `period_in` in DIV_W: new frame period in cycles.
- `period_load` in 1: pulse; latch `period_in`.
- `dir` in 1: 0 = forward (+1), 1 = reverse (−1); sampled at each advance.
- `loop` in 1: 1 = wrap at the ends; 0 = halt at the ends.
- `frame_idx` out FRAME_W: current frame, registered.
- `frame_tick` out 1: one-cycle pulse in the cycle after `frame_idx` changes.
- `done` out 1: one-cycle pulse when an advance is blocked at an end (`loop`=0).
- `state` out 2: 00 STOP, 01 PLAY, 10 PAUSE.

## Operation
- Reset: `state`=STOP, `frame_idx`=0, phase counter=0, `period_reg`=DEFAULT_PERIOD, `frame_tick`=0, `done`=0.
- **Command priority** (same cycle): stop > pause > play > step. Lower-priority commands in that cycle are ignored.
- **STOP**:
  - `cmd_play` → PLAY.
  - `cmd_step` → one advance, then PAUSE.
  - `cmd_pause` → no effect.
- **PLAY**:
  - Each cycle: if count==period_reg−1, then count←0 and one advance; else count←count+1.
  - `cmd_pause` → PAUSE, count frozen.
  - `cmd_step` → ignored.
  - `cmd_stop` → STOP, count←0, `frame_idx`←0.
- **PAUSE**:
  - `cmd_play` → PLAY; resumes from the frozen count, so phase is preserved.
  - `cmd_step` → one advance; count←0; stays PAUSE.
- **cmd_stop from any state**: `frame_idx`←0, count←0, `state`←STOP; no `frame_tick`.
- **Advance**:
  - Forward: `frame_idx`+1. Reverse: `frame_idx`−1.
  - At NUM_FRAMES−1 forward, or 0 reverse, with `loop`=1: wrap to 0 or NUM_FRAMES−1 respectively; `frame_tick` pulses.
  - At an end with `loop`=0: `frame_idx` unchanged, no `frame_tick`, `done` pulses, `state`←PAUSE, count←0.
- **period_load**: `period_reg`←`period_in`, with 0 coerced to 1; count←0. It is accepted in any state and in parallel with commands. If a period wrap coincides with `period_load`, the advance still occurs. The new period governs from the next cycle.
- Period 1: in PLAY, an advance occurs every cycle.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Step latency: `cmd_step` sampled at edge k → `frame_idx` and `frame_tick` updated at edge k (visible in cycle k+1).
- Play latency from STOP (count=0): `cmd_play` sampled at edge k → first `frame_tick` registered at edge k+P, where P=`period_reg`. Subsequent ticks follow every P cycles.
- Pause/resume: cycles spent in PAUSE do not count. Total PLAY cycles between ticks is exactly P.
- `state` reflects a command one cycle after the command's edge.
- `rst` asserted mid-playback: all outputs return to their reset values at that edge. Commands in that cycle are ignored.
- `frame_tick` and `done` are never high in the same cycle.

## Test plan
- Reset then play: NUM_FRAMES=4, period_load 3, cmd_play → `frame_tick` every 3 cycles; `frame_idx` 1,2,3,0,1; `state`=01.
- Loop=0 end: forward play from frame 2 at period 2 → tick to 3; next wrap point gives `done`=1, `frame_idx` stays 3, `state`=10, no tick.
- Pause/resume phase: period 5, pause after 2 counted cycles, hold 10 cycles, play → next tick exactly 3 PLAY cycles later.
- Step and reverse: from STOP, `dir`=1, `loop`=1, cmd_step → `frame_idx`=3 one cycle later, `state`=10; second step → 2.
- Simultaneous commands: cmd_stop+cmd_play in PLAY at frame 2 → `frame_idx`=0, `state`=00, no tick. cmd_pause+cmd_play → PAUSE.
- Period edge cases: period_load 0 → ticks every cycle. `rst` mid-PLAY → `frame_idx`=0, `period_reg`=DEFAULT_PERIOD, `state`=00.
